// File: rtl/mulmod_responder.sv
// Enable/done responder returning (mul1 * mul2) mod P using a bit-serial
// interleaved modular multiplier, MSB first, one operand bit per cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for an armed enable; result held
// ST_LOAD | reduce captured mul1 below P, clear accumulator, cnt = 63
// ST_RUN  | acc = 2*acc (+ a if b[cnt]) mod P, cnt counts down to 0
// ST_FIX  | apply sign: result = P - acc for a negative nonzero product
// ST_DONE | one-cycle done pulse, busy drops on the way out
module mulmod_responder #(
    parameter logic [63:0] P = 64'hFFFF_FFFF_0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [63:0] mul1,
    input  logic [63:0] mul2,
    input  logic        mul1_sign,
    input  logic        mul2_sign,
    output logic [63:0] result,
    output logic        done,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t      state, state_nxt;
    logic        armed;
    logic        accept;
    logic        sign;
    logic [63:0] a, b, acc;
    logic [5:0]  cnt;

    logic        dbl_carry, sum_carry;
    logic [63:0] dbl, dbl_red, sum, step;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && armed) begin
                    accept    = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN:  if (cnt == 6'd0) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Carries stand in for bit 64 of the 65-bit compares; the reduced values
    // are always below P, so 64-bit wrap-around subtraction is exact.
    always_comb begin
        dbl_carry = acc[63];
        dbl       = {acc[62:0], 1'b0};
        dbl_red   = (dbl_carry || dbl >= P) ? dbl - P : dbl;
        {sum_carry, sum} = {1'b0, dbl_red} + {1'b0, a};
        step      = dbl_red;
        if (b[cnt])
            step = (sum_carry || sum >= P) ? sum - P : sum;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed  <= 1'b1;
            sign   <= 1'b0;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            if (accept)       armed <= 1'b0;
            else if (!enable) armed <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a    <= mul1;
                        b    <= mul2;
                        sign <= mul1_sign ^ mul2_sign;
                        busy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // 2^64 < 2P, so a single conditional subtract suffices
                    a   <= (a >= P) ? a - P : a;
                    acc <= '0;
                    cnt <= 6'd63;
                end
                ST_RUN: begin
                    acc <= step;
                    if (cnt != 6'd0) cnt <= cnt - 6'd1;
                end
                ST_FIX: begin
                    result <= (sign && acc != 64'd0) ? P - acc : acc;
                    done   <= 1'b1;
                end
                ST_DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
